if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h00000000: PC value loaded on reset.
REQ-002 Parameter NOP_INSTR, default 32'h00000013: instruction word used for a pipeline bubble.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 stall  input  1  hazard unit request to hold PC and the IF/ID register.
REQ-006 flush  input  1  request to turn the IF/ID register into a bubble.
REQ-007 redirect_valid  input  1  taken branch/jump from a later stage.
REQ-008 redirect_pc  input  32  branch/jump target.
REQ-009 pc_out  output  32  current fetch address, driven to the instruction memory.
REQ-010 instr_in  input  32  instruction returned combinationally by the instruction memory for pc_out.
REQ-011 ifid_valid  output  1  IF/ID register holds a real instruction.
REQ-012 ifid_pc  output  32  PC of the instruction in IF/ID.
REQ-013 ifid_pc_plus4  output  32  ifid_pc + 4, modulo 2^32.
REQ-014 ifid_instr  output  32  instruction in IF/ID; NOP_INSTR when ifid_valid=0.
REQ-015 fetch_count  output  32  count of instructions accepted into IF/ID.

Function
REQ-016 pc_out SHALL be the registered PC; it SHALL NOT depend combinationally on any input.
REQ-017 Per-cycle priority SHALL be rst > redirect_valid > stall > normal advance.
REQ-018 Normal cycle (no rst, no redirect, no stall): PC <= PC+4; IF/ID <= {valid=1, pc_out, pc_out+4, instr_in}, unless flush=1.
REQ-019 PC+4 SHALL wrap modulo 2^32 (32'hFFFFFFFC -> 32'h00000000), with no flag raised.
REQ-020 redirect_valid=1: PC <= {redirect_pc[31:2], 2'b00}; IF/ID SHALL become a bubble (wrong-path fetch discarded), regardless of stall or flush.
REQ-021 stall=1 without redirect: PC SHALL hold; IF/ID SHALL hold its contents unless flush=1.
REQ-022 flush=1 without redirect: IF/ID SHALL become a bubble (valid=0, instr=NOP_INSTR, pc and pc_plus4 = 0); PC SHALL advance when stall=0 and hold when stall=1.
REQ-023 A bubble SHALL carry ifid_instr=NOP_INSTR, ifid_pc=0 and ifid_pc_plus4=0.
REQ-024 fetch_count SHALL increment by 1 exactly in cycles in which IF/ID loads with valid=1, and SHALL wrap at 2^32.
REQ-025 Fetch-to-IF/ID latency SHALL be one cycle: the instruction at pc_out in cycle N appears on ifid_instr in cycle N+1.

Reset
REQ-026 When rst=1 at a rising edge: PC <= RESET_PC; IF/ID <= bubble; fetch_count <= 0; all other inputs ignored.
REQ-027 Reset asserted mid-stall or mid-redirect SHALL take effect at the same edge, with no residual state.
REQ-028 The first cycle after reset deassertion SHALL fetch RESET_PC, and ifid_valid SHALL rise one cycle later.

Structure
REQ-029 NOP_INSTR, RESET_PC default and the bubble encoding SHALL live in the shared pipeline definitions header used by all stages.
REQ-030 The PC register, with its hold/redirect/increment logic, SHALL be one sub-module, pc_register; the IF/ID register and fetch_count SHALL stay in if_stage.

Verification
REQ-031 Reset, then 4 free-running cycles with the instruction memory preloaded -> pc_out 0,4,8,12; ifid_pc 0,4,8 with ifid_valid=1 from cycle 2; fetch_count=3.
REQ-032 stall=1 for 2 cycles at pc_out=8 -> pc_out stays 8 and ifid_pc stays 4 for 2 cycles; fetch_count frozen.
REQ-033 redirect_valid=1, redirect_pc=32'h00000043 at pc_out=12 -> next pc_out=32'h00000040; ifid_valid=0, ifid_instr=32'h00000013.
REQ-034 redirect_valid=1 with stall=1 and flush=1 in the same cycle -> redirect applied, IF/ID bubble, PC not held.
REQ-035 PC forced to 32'hFFFFFFFC via redirect, then a normal cycle -> pc_out=0; ifid_pc_plus4=32'h00000000.
REQ-036 rst=1 during stall=1 at pc_out=32'h20 -> next cycle pc_out=RESET_PC, ifid_valid=0, fetch_count=0.

Source files
------------

// File: rtl/if_stage_pkg.sv
// Shared pipeline definitions: reset PC, bubble encoding and IF/ID register layout.
package if_stage_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

  typedef enum logic [1:0] {
    PC_HOLD     = 2'd0,
    PC_ADVANCE  = 2'd1,
    PC_REDIRECT = 2'd2
  } pc_sel_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] instr;
  } ifid_t;

  function automatic ifid_t ifid_bubble(input logic [31:0] nop);
    ifid_t b;
    b.valid    = 1'b0;
    b.pc       = 32'h0;
    b.pc_plus4 = 32'h0;
    b.instr    = nop;
    return b;
  endfunction

  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return addr & ~32'h3;
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// Fetch-stage bus: hazard controls, redirect, instruction memory and IF/ID outputs.
interface if_stage_if;
  logic        stall;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] pc_out;
  logic [31:0] instr_in;
  logic        ifid_valid;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_pc_plus4;
  logic [31:0] ifid_instr;
  logic [31:0] fetch_count;

  modport master (
    input  stall, flush, redirect_valid, redirect_pc, instr_in,
    output pc_out, ifid_valid, ifid_pc, ifid_pc_plus4, ifid_instr, fetch_count
  );

  modport slave (
    output stall, flush, redirect_valid, redirect_pc, instr_in,
    input  pc_out, ifid_valid, ifid_pc, ifid_pc_plus4, ifid_instr, fetch_count
  );
endinterface

// File: rtl/pc_register.sv
// Program counter: redirect beats stall beats advance; output is purely registered.
module pc_register
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] pc_o
);

  logic [31:0] pc_q;
  logic [31:0] pc_d;
  pc_sel_e     sel;

  always_comb begin
    sel = PC_ADVANCE;
    if (redirect_valid_i) begin
      sel = PC_REDIRECT;
    end else if (stall_i) begin
      sel = PC_HOLD;
    end
  end

  // Increment wraps naturally at 2^32.
  always_comb begin
    pc_d = pc_q;
    case (sel)
      PC_REDIRECT: pc_d = align_pc(redirect_pc_i);
      PC_ADVANCE:  pc_d = pc_q + 32'd4;
      default:     pc_d = pc_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and fetch counter.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  if_stage_if.master bus
);

  logic [31:0] pc;
  ifid_t       ifid_q;
  ifid_t       ifid_d;
  logic [31:0] fetch_count_q;
  logic [31:0] fetch_count_d;
  logic        load_valid;

  pc_register #(
    .RESET_PC(RESET_PC)
  ) u_pc_register (
    .clk             (clk),
    .rst             (rst),
    .stall_i         (bus.stall),
    .redirect_valid_i(bus.redirect_valid),
    .redirect_pc_i   (bus.redirect_pc),
    .pc_o            (pc)
  );

  assign load_valid = !bus.redirect_valid && !bus.stall && !bus.flush;

  // A redirect discards the wrong-path fetch even while stalled.
  always_comb begin
    ifid_d        = ifid_q;
    fetch_count_d = fetch_count_q;
    if (bus.redirect_valid || bus.flush) begin
      ifid_d = ifid_bubble(NOP_INSTR);
    end else if (load_valid) begin
      ifid_d.valid    = 1'b1;
      ifid_d.pc       = pc;
      ifid_d.pc_plus4 = pc + 32'd4;
      ifid_d.instr    = bus.instr_in;
      fetch_count_d   = fetch_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ifid_q        <= ifid_bubble(NOP_INSTR);
      fetch_count_q <= 32'h0;
    end else begin
      ifid_q        <= ifid_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign bus.pc_out        = pc;
  assign bus.ifid_valid    = ifid_q.valid;
  assign bus.ifid_pc       = ifid_q.pc;
  assign bus.ifid_pc_plus4 = ifid_q.pc_plus4;
  assign bus.ifid_instr    = ifid_q.instr;
  assign bus.fetch_count   = fetch_count_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: reset, advance, stall, flush, redirect, wrap, reset-in-stall.
module tb_if_stage;
  import if_stage_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  if_stage_if bus ();

  if_stage dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Instruction memory: word at address A reads as {16'hABCD, A[15:0]}.
  always_comb bus.instr_in = {16'hABCD, bus.pc_out[15:0]};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic [31:0] pc, input logic v,
                           input logic [31:0] ipc, input logic [31:0] instr,
                           input logic [31:0] cnt);
    chk({tag, ".pc_out"}, bus.pc_out, pc);
    chk({tag, ".ifid_valid"}, {31'h0, bus.ifid_valid}, {31'h0, v});
    chk({tag, ".ifid_pc"}, bus.ifid_pc, ipc);
    chk({tag, ".ifid_pc_plus4"}, bus.ifid_pc_plus4, v ? ipc + 32'd4 : 32'h0);
    chk({tag, ".ifid_instr"}, bus.ifid_instr, instr);
    chk({tag, ".fetch_count"}, bus.fetch_count, cnt);
  endtask

  initial begin
    rst                = 1'b1;
    bus.stall          = 1'b0;
    bus.flush          = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    edge_step();
    edge_step();
    chk_state("reset", 32'h0, 1'b0, 32'h0, 32'h13, 32'd0);

    rst = 1'b0;
    #2;
    chk("first_fetch.pc_out", bus.pc_out, 32'h0);
    edge_step();
    chk_state("run1", 32'h4, 1'b1, 32'h0, 32'hABCD0000, 32'd1);
    edge_step();
    chk_state("run2", 32'h8, 1'b1, 32'h4, 32'hABCD0004, 32'd2);

    bus.stall = 1'b1;
    edge_step();
    chk_state("stall1", 32'h8, 1'b1, 32'h4, 32'hABCD0004, 32'd2);
    edge_step();
    chk_state("stall2", 32'h8, 1'b1, 32'h4, 32'hABCD0004, 32'd2);
    bus.stall = 1'b0;
    edge_step();
    chk_state("run3", 32'hC, 1'b1, 32'h8, 32'hABCD0008, 32'd3);

    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h43;
    edge_step();
    chk_state("redirect", 32'h40, 1'b0, 32'h0, 32'h13, 32'd3);
    bus.redirect_valid = 1'b0;
    edge_step();
    chk_state("post_redirect", 32'h44, 1'b1, 32'h40, 32'hABCD0040, 32'd4);

    bus.flush = 1'b1;
    edge_step();
    chk_state("flush", 32'h48, 1'b0, 32'h0, 32'h13, 32'd4);
    bus.stall = 1'b1;
    edge_step();
    chk_state("flush_stall", 32'h48, 1'b0, 32'h0, 32'h13, 32'd4);
    bus.flush = 1'b0;
    bus.stall = 1'b0;
    edge_step();
    chk_state("post_flush", 32'h4C, 1'b1, 32'h48, 32'hABCD0048, 32'd5);

    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h100;
    bus.stall          = 1'b1;
    bus.flush          = 1'b1;
    edge_step();
    chk_state("redirect_all", 32'h100, 1'b0, 32'h0, 32'h13, 32'd5);

    bus.stall       = 1'b0;
    bus.flush       = 1'b0;
    bus.redirect_pc = 32'hFFFF_FFFF;
    edge_step();
    chk_state("redirect_top", 32'hFFFF_FFFC, 1'b0, 32'h0, 32'h13, 32'd5);
    bus.redirect_valid = 1'b0;
    edge_step();
    chk_state("wrap", 32'h0, 1'b1, 32'hFFFF_FFFC, 32'hABCDFFFC, 32'd6);
    chk("wrap.pc_plus4_zero", bus.ifid_pc_plus4, 32'h0);

    for (int i = 1; i <= 8; i++) begin
      edge_step();
      chk($sformatf("walk%0d.pc_out", i), bus.pc_out, 32'(4 * i));
      chk($sformatf("walk%0d.fetch_count", i), bus.fetch_count, 32'(6 + i));
    end

    bus.stall = 1'b1;
    edge_step();
    chk_state("stall_at_20", 32'h20, 1'b1, 32'h1C, 32'hABCD001C, 32'd14);
    rst = 1'b1;
    edge_step();
    chk_state("rst_in_stall", 32'h0, 1'b0, 32'h0, 32'h13, 32'd0);
    rst       = 1'b0;
    bus.stall = 1'b0;
    #2;
    chk("restart.pc_out", bus.pc_out, 32'h0);
    edge_step();
    chk_state("restart1", 32'h4, 1'b1, 32'h0, 32'hABCD0000, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
